cory_rgb2yuv: RTL and testbench

Converts 24-bit RGB pixels to 24-bit YCbCr (BT.601 studio range, 8-bit integer arithmetic). It is the inverse of the YUV-to-RGB converter, using the same packing and valid/ready stream protocol. It is a two-stage registered pipeline with full-throughput back-pressure. It sits on the capture/encode side, ahead of YUV-domain processing.

---
 rtl/cory_rgb2yuv.sv | 102 ++++++++++
 tb/tb_cory_rgb2yuv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cory_rgb2yuv.sv
// rtl/cory_rgb2yuv.sv - two-stage RGB to YCbCr (BT.601 studio range) pipeline with valid/ready back-pressure
module cory_rgb2yuv (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_a_v,
    input  logic [23:0] i_a_d,
    output logic        o_a_r,
    output logic        o_z_v,
    output logic [23:0] o_z_d,
    input  logic        i_z_r
);

    // Stage 1 state: valid flag and the three rounded multiply-accumulate sums
    logic               v1_q, v1_d;
    logic signed [17:0] y1_q, y1_d;
    logic signed [17:0] cb1_q, cb1_d;
    logic signed [17:0] cr1_q, cr1_d;

    // Stage 2 state: valid flag and the packed output pixel
    logic               v2_q, v2_d;
    logic [23:0]        z2_q, z2_d;

    logic               en1, en2;
    logic signed [17:0] r_s, g_s, b_s;

    // Shift out the fractional bits, add the component offset and saturate to a byte.
    // The shift is arithmetic so negative chroma sums floor toward minus infinity.
    function automatic logic [7:0] clamp_off(input logic signed [17:0] sum,
                                             input logic signed [17:0] off);
        logic signed [17:0] t;
        t = (sum >>> 8) + off;
        if (t < 18'sd0) begin
            clamp_off = 8'h00;
        end else if (t > 18'sd255) begin
            clamp_off = 8'hff;
        end else begin
            clamp_off = t[7:0];
        end
    endfunction

    // Stage enables: a stage may advance when it is empty or the stage after it advances
    always_comb begin
        en2   = !v2_q || i_z_r;
        en1   = !v1_q || en2;
        o_a_r = en1;
    end

    // Stage 1 next state: widen the channels and form the weighted sums with the +128 rounding term
    always_comb begin
        r_s   = $signed({10'd0, i_a_d[23:16]});
        g_s   = $signed({10'd0, i_a_d[15:8]});
        b_s   = $signed({10'd0, i_a_d[7:0]});
        v1_d  = v1_q;
        y1_d  = y1_q;
        cb1_d = cb1_q;
        cr1_d = cr1_q;
        if (en1) begin
            v1_d  = i_a_v;
            y1_d  = (18'sd66 * r_s) + (18'sd129 * g_s) + (18'sd25 * b_s) + 18'sd128;
            cb1_d = (18'sd112 * b_s) - (18'sd38 * r_s) - (18'sd74 * g_s) + 18'sd128;
            cr1_d = (18'sd112 * r_s) - (18'sd94 * g_s) - (18'sd18 * b_s) + 18'sd128;
        end
    end

    // Stage 2 next state: scale, offset, clamp and pack {Y, Cb, Cr}
    always_comb begin
        v2_d = v2_q;
        z2_d = z2_q;
        if (en2) begin
            v2_d = v1_q;
            z2_d = {clamp_off(y1_q, 18'sd16),
                    clamp_off(cb1_q, 18'sd128),
                    clamp_off(cr1_q, 18'sd128)};
        end
    end

    // Pipeline registers; reset discards every in-flight pixel and clears the data path
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            y1_q  <= '0;
            cb1_q <= '0;
            cr1_q <= '0;
            v2_q  <= 1'b0;
            z2_q  <= '0;
        end else begin
            v1_q  <= v1_d;
            y1_q  <= y1_d;
            cb1_q <= cb1_d;
            cr1_q <= cr1_d;
            v2_q  <= v2_d;
            z2_q  <= z2_d;
        end
    end

    // Outputs come straight from the stage 2 flops
    always_comb begin
        o_z_v = v2_q;
        o_z_d = z2_q;
    end

endmodule

// File: tb/tb_cory_rgb2yuv.sv
// tb/tb_cory_rgb2yuv.sv - scoreboard bench for cory_rgb2yuv
module tb_cory_rgb2yuv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_a_v = 1'b0;
    logic [23:0] i_a_d = 24'h0;
    logic        o_a_r;
    logic        o_z_v;
    logic [23:0] o_z_d;
    logic        i_z_r = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    logic [23:0] sb_q[$];
    bit          gap_chk = 1'b0;
    bit          use_tab = 1'b0;
    logic [23:0] tab_exp = 24'h0;
    logic [1:0]  acc_h = 2'b00;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_d = 24'h0;
    bit          last_rdy = 1'b0;

    always #5 clk = ~clk;

    cory_rgb2yuv dut (
        .clk   (clk),
        .reset (reset),
        .i_a_v (i_a_v),
        .i_a_d (i_a_d),
        .o_a_r (o_a_r),
        .o_z_v (o_z_v),
        .o_z_d (o_z_d),
        .i_z_r (i_z_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    function automatic logic [7:0] clip(input int v);
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hff;
        return v[7:0];
    endfunction

    function automatic logic [23:0] ref_yuv(input logic [23:0] p);
        int r, g, b, y, cb, cr;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        y  = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16;
        cb = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128;
        cr = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128;
        return {clip(y), clip(cb), clip(cr)};
    endfunction

    // Monitor: sampled on the falling edge, decides what the next rising edge transfers
    always @(negedge clk) begin
        logic [23:0] exp_d;
        if (reset) begin
            sb_q.delete();
            acc_h = 2'b00;
            prev_stall = 1'b0;
        end else begin
            check("ready", {31'd0, o_a_r}, {31'd0, (sb_q.size() < 2) || i_z_r});
            if (prev_stall) begin
                check("stall_v", {31'd0, o_z_v}, 32'd1);
                check("stall_d", {8'd0, o_z_d}, {8'd0, prev_d});
            end
            if (gap_chk) check("lat_v", {31'd0, o_z_v}, {31'd0, acc_h[1]});
            if (o_z_v && i_z_r) begin
                if (sb_q.size() == 0) begin
                    check("spurious", {31'd0, o_z_v}, 32'd0);
                end else begin
                    exp_d = sb_q.pop_front();
                    check("data", {8'd0, o_z_d}, {8'd0, exp_d});
                end
            end
            if (i_a_v && o_a_r) sb_q.push_back(use_tab ? tab_exp : ref_yuv(i_a_d));
            acc_h = {acc_h[0], i_a_v && o_a_r};
            prev_stall = o_z_v && !i_z_r;
            prev_d = o_z_d;
        end
    end

    // One cycle of stimulus; reports whether the offered pixel was accepted
    task automatic cyc(input logic v, input logic [23:0] d, input logic zr, output bit acc);
        i_a_v = v;
        i_a_d = d;
        i_z_r = zr;
        @(negedge clk);
        last_rdy = o_a_r;
        acc = v && o_a_r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) cyc(1'b0, 24'h0, 1'b1, a);
        cyc(1'b0, 24'h0, 1'b1, a);
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    logic [23:0] bar_in[5]  = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    logic [23:0] bar_out[5] = '{24'h108080, 24'hEB8080, 24'h525AF0, 24'h903622, 24'h29F06E};
    logic        gap_pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        bit a;
        bit saw_drop;
        int idx;
        int n_acc;
        logic [23:0] pix;

        // Reset and check idle state, ready must not depend on downstream ready
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        i_z_r = 1'b0;
        @(negedge clk);
        check("rst_v", {31'd0, o_z_v}, 32'd0);
        check("rst_d", {8'd0, o_z_d}, 32'd0);
        check("rst_r", {31'd0, o_a_r}, 32'd1);
        @(posedge clk);
        #1;

        // Colour bars back to back, then gapped valid pattern, with latency tracking
        cyc(1'b0, 24'h0, 1'b1, a);
        cyc(1'b0, 24'h0, 1'b1, a);
        gap_chk = 1'b1;
        use_tab = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tab_exp = bar_out[k];
            cyc(1'b1, bar_in[k], 1'b1, a);
            check("bar_acc", {31'd0, a}, 32'd1);
        end
        use_tab = 1'b0;
        for (int k = 0; k < 8; k++) cyc(gap_pat[k], $urandom, 1'b1, a);
        cyc(1'b0, 24'h0, 1'b1, a);
        cyc(1'b0, 24'h0, 1'b1, a);
        gap_chk = 1'b0;
        drain();

        // Back-pressure: 8 pixels, downstream stalled for cycles 3..6
        idx = 0;
        saw_drop = 1'b0;
        for (int c = 0; idx < 8 && c < 100; c++) begin
            cyc(1'b1, 24'h102030 + 24'(idx * 24'h1F2E3D), !(c >= 3 && c <= 6), a);
            if (!last_rdy) saw_drop = 1'b1;
            if (a) idx++;
        end
        check("bp_drop", {31'd0, saw_drop}, 32'd1);
        check("bp_sent", idx, 32'd8);
        drain();

        // Reset mid-stream with both stages full and a transfer offered on both sides
        last_rdy = 1'b1;
        for (int k = 0; k < 10 && last_rdy; k++) cyc(1'b1, $urandom, 1'b0, a);
        check("rm_full", {31'd0, last_rdy}, 32'd0);
        reset = 1'b1;
        i_a_v = 1'b1;
        i_a_d = 24'hABCDEF;
        i_z_r = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_a_v = 1'b0;
        i_z_r = 1'b0;
        @(negedge clk);
        check("rm_v", {31'd0, o_z_v}, 32'd0);
        check("rm_d", {8'd0, o_z_d}, 32'd0);
        check("rm_r", {31'd0, o_a_r}, 32'd1);
        @(posedge clk);
        #1;
        cyc(1'b1, 24'h123456, 1'b1, a);
        check("rm_acc", {31'd0, a}, 32'd1);
        drain();

        // Random traffic: mid-grey first, then 10k pixels at 50% valid / 50% ready
        a = 1'b0;
        for (int k = 0; k < 20 && !a; k++) cyc(1'b1, 24'h808080, 1'b1, a);
        n_acc = 0;
        for (int c = 0; n_acc < 10000 && c < 60000; c++) begin
            pix = $urandom;
            cyc(1'($urandom_range(0, 1)), pix, 1'($urandom_range(0, 1)), a);
            if (a) n_acc++;
        end
        check("rand_n", n_acc, 32'd10000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
